keypad_entry: RTL and testbench

//  Front-panel digit entry stage directly upstream of the microwave timer.

---
 rtl/microondas_pkg.sv | 33 +++
 rtl/key_debouncer.sv | 57 +++++
 rtl/keypad_entry.sv | 127 ++++++++++++
 tb/tb_keypad_entry.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/microondas_pkg.sv
// Shared widths, FSM states and BCD helpers for the microwave front-panel keypad path.
package microondas_pkg;

   localparam int KEY_W      = 10;
   localparam int DIGIT_W    = 4;
   localparam int MAX_DIGITS = 3;

   typedef enum logic [1:0] {
      ST_IDLE         = 2'd0,
      ST_DEBOUNCE     = 2'd1,
      ST_LOAD         = 2'd2,
      ST_WAIT_RELEASE = 2'd3
   } state_e;

   function automatic logic is_onehot(input logic [KEY_W-1:0] v);
      return (v != '0) && ((v & (v - 1'b1)) == '0);
   endfunction

   // Non-one-hot inputs encode to 0 so a stray multi-key pattern never produces a bogus digit.
   function automatic logic [DIGIT_W-1:0] onehot_to_bcd(input logic [KEY_W-1:0] v);
      logic [DIGIT_W-1:0] bcd;
      bcd = '0;
      if (is_onehot(v)) begin
         for (int i = 0; i < KEY_W; i++) begin
            if (v[i]) begin
               bcd = DIGIT_W'(i);
            end
         end
      end
      return bcd;
   endfunction

endpackage

// File: rtl/key_debouncer.sv
// Two-flop key synchroniser plus a counter of consecutive cycles the synchronised
// pattern has held; the owning FSM decides what a stable pattern means.
module key_debouncer
   import microondas_pkg::*;
#(
   parameter int N = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [KEY_W-1:0] keys,
   input  logic             start,
   output logic [KEY_W-1:0] ks,
   output logic [KEY_W-1:0] pattern,
   output logic             stable
);

   localparam int CW = $clog2(N + 1);

   logic [KEY_W-1:0] sync1_q, sync1_d;
   logic [KEY_W-1:0] sync2_q, sync2_d;
   logic [KEY_W-1:0] pattern_q, pattern_d;
   logic [CW-1:0]    cnt_q, cnt_d;

   // A changed pattern (or an explicit start) begins a fresh run of length one.
   always_comb begin
      sync1_d   = keys;
      sync2_d   = sync1_q;
      pattern_d = pattern_q;
      cnt_d     = cnt_q;
      if (start || (sync2_q != pattern_q)) begin
         pattern_d = sync2_q;
         cnt_d     = CW'(1);
      end else if (cnt_q != CW'(N)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         sync1_q   <= '0;
         sync2_q   <= '0;
         pattern_q <= '0;
         cnt_q     <= '0;
      end else begin
         sync1_q   <= sync1_d;
         sync2_q   <= sync2_d;
         pattern_q <= pattern_d;
         cnt_q     <= cnt_d;
      end
   end

   assign ks      = sync2_q;
   assign pattern = pattern_q;
   // High in the cycle whose sample completes N consecutive matching samples.
   assign stable  = (sync2_q == pattern_q) && (cnt_q >= CW'(N - 1));

endmodule

// File: rtl/keypad_entry.sv
// Keypad digit entry: debounces ten decimal keys and issues one active-low load
// strobe with a BCD digit per accepted press, up to MAX_DIGITS digits.
module keypad_entry
   import microondas_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 8,
   parameter int MAX_DIGITS      = microondas_pkg::MAX_DIGITS
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [KEY_W-1:0]   keys,
   input  logic               entry_en,
   input  logic               clear_entry,
   output logic [DIGIT_W-1:0] data,
   output logic               loadn,
   output logic [1:0]         digit_count,
   output logic               full,
   output logic               key_error
);

   state_e             state_q, state_d;
   logic [DIGIT_W-1:0] data_q, data_d;
   logic               loadn_q, loadn_d;
   logic [1:0]         count_q, count_d;
   logic               key_error_q, key_error_d;

   logic [KEY_W-1:0]   ks;
   logic [KEY_W-1:0]   pattern;
   logic               stable;
   logic               start;

   key_debouncer #(.N(DEBOUNCE_CYCLES)) u_debouncer (
      .clock   (clock),
      .reset   (reset),
      .keys    (keys),
      .start   (start),
      .ks      (ks),
      .pattern (pattern),
      .stable  (stable)
   );

   assign full = (count_q == 2'(MAX_DIGITS));

   // A key already down while entry is disallowed must be released before it can count,
   // so IDLE parks in WAIT_RELEASE instead of waiting for entry_en with the key held.
   always_comb begin
      state_d     = state_q;
      data_d      = data_q;
      loadn_d     = 1'b1;
      count_d     = count_q;
      key_error_d = 1'b0;
      start       = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (ks != '0) begin
               if (entry_en) begin
                  start   = 1'b1;
                  state_d = ST_DEBOUNCE;
               end else begin
                  state_d = ST_WAIT_RELEASE;
               end
            end
         end
         ST_DEBOUNCE: begin
            if (!entry_en) begin
               state_d = ST_WAIT_RELEASE;
            end else if (ks != pattern) begin
               state_d = ST_IDLE;
            end else if (stable) begin
               if (!is_onehot(pattern)) begin
                  key_error_d = 1'b1;
                  state_d     = ST_WAIT_RELEASE;
               end else if (full) begin
                  state_d = ST_WAIT_RELEASE;
               end else begin
                  state_d = ST_LOAD;
               end
            end
         end
         ST_LOAD: begin
            state_d = ST_WAIT_RELEASE;
            if (!clear_entry) begin
               loadn_d = 1'b0;
               data_d  = onehot_to_bcd(pattern);
               if (!full) begin
                  count_d = count_q + 1'b1;
               end
            end
         end
         ST_WAIT_RELEASE: begin
            if ((ks == '0) && stable) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      // Clearing with a key still down must not let that same press be reloaded.
      if (clear_entry) begin
         count_d = '0;
         if (ks != '0) begin
            state_d = ST_WAIT_RELEASE;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         data_q      <= '0;
         loadn_q     <= 1'b1;
         count_q     <= '0;
         key_error_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         data_q      <= data_d;
         loadn_q     <= loadn_d;
         count_q     <= count_d;
         key_error_q <= key_error_d;
      end
   end

   assign data        = data_q;
   assign loadn       = loadn_q;
   assign digit_count = count_q;
   assign key_error   = key_error_q;

endmodule

// File: tb/tb_keypad_entry.sv
// Directed bench for keypad_entry: strobe timing, bounce rejection, entry limit,
// multi-key error, clear/reset interactions and entry_en gating.
module tb_keypad_entry;

   logic       clock;
   logic       reset;
   logic [9:0] keys;
   logic       entry_en;
   logic       clear_entry;
   logic [3:0] data;
   logic       loadn;
   logic [1:0] digit_count;
   logic       full;
   logic       key_error;

   int tests_run;
   int tests_failed;
   int load_seen;
   int err_seen;
   int load_base;
   int err_base;
   int first_low;

   keypad_entry #(.DEBOUNCE_CYCLES(8), .MAX_DIGITS(3)) dut (
      .clock       (clock),
      .reset       (reset),
      .keys        (keys),
      .entry_en    (entry_en),
      .clear_entry (clear_entry),
      .data        (data),
      .loadn       (loadn),
      .digit_count (digit_count),
      .full        (full),
      .key_error   (key_error)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(negedge clock) begin
      if (loadn === 1'b0) load_seen++;
      if (key_error === 1'b1) err_seen++;
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clock);
         @(negedge clock);
      end
   endtask

   task automatic applyStimulus(input logic [9:0] k, input int hold, input int rel);
      keys = k;
      cycles(hold);
      keys = '0;
      cycles(rel);
   endtask

   task automatic pulseClear();
      clear_entry = 1'b1;
      cycles(1);
      clear_entry = 1'b0;
      cycles(1);
   endtask

   task automatic findFirstLow(input int n);
      first_low = 0;
      for (int e = 1; e <= n; e++) begin
         @(posedge clock);
         @(negedge clock);
         if ((loadn === 1'b0) && (first_low == 0)) first_low = e;
      end
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      load_seen    = 0;
      err_seen     = 0;
      reset        = 1'b1;
      keys         = '0;
      entry_en     = 1'b1;
      clear_entry  = 1'b0;
      cycles(3);
      checkOutput("rst_data", data, 0);
      checkOutput("rst_loadn", loadn, 1);
      checkOutput("rst_count", digit_count, 0);
      checkOutput("rst_full", full, 0);
      checkOutput("rst_keyerr", key_error, 0);
      reset = 1'b0;
      cycles(3);

      // 1: single press of digit 5, strobe on edge 11
      load_base = load_seen;
      keys = 10'h020;
      findFirstLow(20);
      checkOutput("t1_edge", first_low, 11);
      checkOutput("t1_loads", load_seen - load_base, 1);
      checkOutput("t1_data", data, 5);
      checkOutput("t1_count", digit_count, 1);
      keys = '0;
      cycles(15);

      // 2: bouncing key 3, then stable
      load_base = load_seen;
      for (int b = 0; b < 4; b++) begin
         keys = 10'h008;
         cycles(3);
         keys = '0;
         cycles(3);
      end
      checkOutput("t2_bounce_loads", load_seen - load_base, 0);
      applyStimulus(10'h008, 20, 15);
      checkOutput("t2_loads", load_seen - load_base, 1);
      checkOutput("t2_data", data, 3);
      checkOutput("t2_count", digit_count, 2);

      // 3: three digits fill the entry, the fourth is dropped
      pulseClear();
      checkOutput("t3_cleared", digit_count, 0);
      load_base = load_seen;
      err_base  = err_seen;
      applyStimulus(10'h002, 20, 15);
      checkOutput("t3_d1", data, 1);
      applyStimulus(10'h004, 20, 15);
      checkOutput("t3_d2", data, 2);
      checkOutput("t3_full_before", full, 0);
      applyStimulus(10'h008, 20, 15);
      checkOutput("t3_d3", data, 3);
      checkOutput("t3_full", full, 1);
      checkOutput("t3_count3", digit_count, 3);
      applyStimulus(10'h010, 20, 15);
      checkOutput("t3_loads", load_seen - load_base, 3);
      checkOutput("t3_data_kept", data, 3);
      checkOutput("t3_count_sat", digit_count, 3);
      checkOutput("t3_no_err", err_seen - err_base, 0);

      // 4: two keys at once
      load_base = load_seen;
      err_base  = err_seen;
      applyStimulus(10'h006, 20, 15);
      checkOutput("t4_err", err_seen - err_base, 1);
      checkOutput("t4_loads", load_seen - load_base, 0);
      checkOutput("t4_count", digit_count, 3);

      // 5: clear in the LOAD cycle of key 7
      pulseClear();
      load_base = load_seen;
      keys = 10'h080;
      cycles(10);
      clear_entry = 1'b1;
      cycles(1);
      clear_entry = 1'b0;
      checkOutput("t5_loadn", loadn, 1);
      checkOutput("t5_count", digit_count, 0);
      checkOutput("t5_data", data, 3);
      cycles(20);
      keys = '0;
      cycles(15);
      checkOutput("t5_no_reload", load_seen - load_base, 0);
      applyStimulus(10'h080, 20, 15);
      checkOutput("t5_reload", load_seen - load_base, 1);
      checkOutput("t5_data7", data, 7);
      checkOutput("t5_count1", digit_count, 1);

      // 6: reset while debouncing key 9
      load_base = load_seen;
      keys = 10'h200;
      cycles(5);
      reset = 1'b1;
      cycles(1);
      checkOutput("t6_data", data, 0);
      checkOutput("t6_loadn", loadn, 1);
      checkOutput("t6_count", digit_count, 0);
      checkOutput("t6_full", full, 0);
      checkOutput("t6_keyerr", key_error, 0);
      reset = 1'b0;
      findFirstLow(20);
      checkOutput("t6_edge", first_low, 11);
      checkOutput("t6_loads", load_seen - load_base, 1);
      checkOutput("t6_data9", data, 9);
      checkOutput("t6_count1", digit_count, 1);
      keys = '0;
      cycles(15);

      // 7: key 4 held while entry disabled
      load_base = load_seen;
      entry_en = 1'b0;
      keys = 10'h010;
      cycles(30);
      checkOutput("t7_disabled", load_seen - load_base, 0);
      entry_en = 1'b1;
      cycles(20);
      checkOutput("t7_enabled_held", load_seen - load_base, 0);
      keys = '0;
      cycles(15);
      applyStimulus(10'h010, 20, 15);
      checkOutput("t7_loads", load_seen - load_base, 1);
      checkOutput("t7_data", data, 4);
      checkOutput("t7_count", digit_count, 2);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
